add_issue_collect: RTL and testbench
====================================

// Module: add_issue_collect
// PURPOSE
//  Initiator/collector for the two-stage pipelined adder (start/a/b in, y/valid out).
//  Accepts operand pairs from upstream on a valid/ready handshake and drives adder_start/a/b.
//  Captures each adder_y on adder_valid into an in-order result FIFO and returns results downstream.
//  Credit tracking guarantees every issued op has a reserved result slot, so no result is lost.
// PARAMETERS
//  W        10  operand/result width (must match the adder)
//  DEPTH    4   result FIFO entries = max in-flight + buffered results (power of 2, >=2)
//  TIMEOUT  16  cycles with ops outstanding and no adder_valid before err_timeout is set
// PORTS
//  clk           in   1                      clock, rising edge
//  rst_n         in   1                      reset: asynchronous, active-low (shared with the adder)
//  in_valid      in   1                      upstream operand pair valid
//  in_ready      out  1                      block can accept a pair this cycle
//  in_a, in_b    in   W                      operands
//  adder_start   out  1                      one-cycle issue strobe to the adder
//  adder_a/b     out  W                      operands to the adder, valid while adder_start=1
//  adder_y       in   W                      adder result
//  adder_valid   in   1                      adder result strobe
//  out_valid     out  1                      result FIFO non-empty
//  out_ready     in   1                      downstream accepts out_y
//  out_y         out  W                      head-of-FIFO result
//  outstanding   out  $clog2(DEPTH+1)        issued ops awaiting adder_valid
//  err_protocol  out  1                      sticky: adder_valid with outstanding==0, or push into full FIFO
//  err_timeout   out  1                      sticky: watchdog expired
// BEHAVIOUR
//  Reset: in_ready=0 during reset. After reset, in_ready follows the credit rule.
//   All other outputs reset to 0, FIFO pointers/count=0, watchdog=0.
//  Credit: credits = DEPTH - fifo_count - outstanding. in_ready = (credits!=0) && !err_timeout (combinational).
//  Accept: if in_valid && in_ready at edge t:
//   adder_start=1 and adder_a/b=in_a/in_b are registered for cycle t+1.
//   outstanding increments at edge t. adder_start is low on all other cycles.
//   Back-to-back accepts are allowed (one per cycle).
//  Collect: on adder_valid with outstanding!=0, push adder_y and decrement outstanding.
//   Accept and collect in the same cycle leave outstanding unchanged.
//   Spurious adder_valid (outstanding==0): not pushed; err_protocol=1.
//   Push when FIFO full (only possible if spurious): dropped; err_protocol=1.
//  Ordering: results are returned strictly in acceptance order. No fixed adder latency is assumed.
//   With the current adder, accept at t -> push at edge t+3 -> out_valid at t+3.
//  Output: out_valid = (fifo_count!=0); out_y = mem[rd_ptr]; pop on out_valid && out_ready.
//   Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
//  Arithmetic: results are passed through unmodified (adder wraps mod 2^W); no width growth.
//  Watchdog:
//   Counts cycles with outstanding!=0 && !adder_valid. Clears on adder_valid or when outstanding==0.
//   Reaching TIMEOUT sets err_timeout, which blocks further accepts.
//   Already-buffered results still drain.
//  Errors clear only on reset. Reset mid-operation discards all in-flight and buffered results.
//   The adder shares rst_n, so no stale adder_valid follows.
// STRUCTURE
//  Package add_if_pkg: typedef logic [W-1:0] operand_t; localparams DEPTH_DEF, TIMEOUT_DEF; cnt_t width helper.
//  Sub-module sync_fifo_w (W x DEPTH, push/pop/full/empty/count).
//  Top holds the issue register, outstanding counter, credit logic, watchdog and error flags.
// TESTING
//  1) accept a=3,b=4, out_ready=1 -> adder_start one cycle at t+1 with 3/4; out_y=7, out_valid at t+3; outstanding back to 0.
//  2) out_ready=0, in_valid held with 4 pairs -> in_ready drops after the 4th accept; release out_ready -> results in order, in_ready reasserts.
//  3) a=1023,b=1 (W=10) -> out_y=0; a=512,b=512 -> out_y=0.
//  4) adder_valid pulsed with outstanding=0 -> err_protocol=1, FIFO count unchanged, stays set until reset.
//  5) adder model stalled after accept -> err_timeout=1 exactly 16 cycles after adder_start; in_ready=0 thereafter.
//  6) rst_n low with 2 ops in flight and 1 buffered -> out_valid=0, outstanding=0, errors 0; next op after reset returns a correct result.

Source files
------------

// File: rtl/add_if_pkg.sv
// Shared types, defaults and width helper for the adder issue/collect block.
package add_if_pkg;

  localparam int unsigned W_DEF       = 10;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef logic [W_DEF-1:0] operand_t;

  // Operand pair as carried on the upstream bus
  typedef struct packed {
    operand_t a;
    operand_t b;
  } op_pair_t;

  // Bits needed to hold a count in the range 0..n
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/add_issue_collect_if.sv
// Upstream, adder-side and downstream signals of the issue/collect block.
interface add_issue_collect_if
  import add_if_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
);

  localparam int unsigned OW = cnt_w(DEPTH);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;

  logic          adder_start;
  logic [W-1:0]  adder_a;
  logic [W-1:0]  adder_b;
  logic [W-1:0]  adder_y;
  logic          adder_valid;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_y;

  logic [OW-1:0] outstanding;
  logic          err_protocol;
  logic          err_timeout;

  // Issue/collect block side
  modport master (
    input  in_valid, in_a, in_b, adder_y, adder_valid, out_ready,
    output in_ready, adder_start, adder_a, adder_b, out_valid, out_y,
           outstanding, err_protocol, err_timeout
  );

  // Environment side: upstream producer, adder, downstream consumer
  modport slave (
    output in_valid, in_a, in_b, adder_y, adder_valid, out_ready,
    input  in_ready, adder_start, adder_a, adder_b, out_valid, out_y,
           outstanding, err_protocol, err_timeout
  );

endinterface

// File: rtl/sync_fifo_w.sv
// In-order result buffer: W bits x DEPTH entries, full push and empty pop are ignored.
module sync_fifo_w
  import add_if_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [W-1:0]            data_i,
  input  logic                    pop_i,
  output logic [W-1:0]            data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [cnt_w(DEPTH)-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push_c;
  logic          do_pop_c;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push_c = push_i && !full_o;
  assign do_pop_c  = pop_i && !empty_o;
  assign data_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage, pointers (wrap modulo DEPTH) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_c, do_pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/add_issue_collect.sv
// Issues operand pairs to the pipelined adder and returns results in order,
// reserving a result slot for every op in flight so none can be lost.
module add_issue_collect
  import add_if_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst_n,
  add_issue_collect_if.master bus
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned UW = CW + 1;
  localparam int unsigned TW = cnt_w(TIMEOUT);

  logic          adder_start_q;
  logic [W-1:0]  adder_a_q;
  logic [W-1:0]  adder_b_q;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          err_protocol_q, err_protocol_d;
  logic          err_timeout_q, err_timeout_d;

  logic          in_ready_c;
  logic          accept_c;
  logic          collect_c;
  logic          spurious_c;
  logic          wd_run_c;
  logic          pop_c;
  logic [UW-1:0] used_c;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [W-1:0]  fifo_head;

  // Slots in use = buffered results plus ops still inside the adder
  assign used_c     = UW'(fifo_count) + UW'(outstanding_q);
  assign in_ready_c = rst_n && (used_c < UW'(DEPTH)) && !err_timeout_q;
  assign accept_c   = bus.in_valid && in_ready_c;
  assign collect_c  = bus.adder_valid && (outstanding_q != '0);
  assign spurious_c = bus.adder_valid && (outstanding_q == '0);
  assign wd_run_c   = (outstanding_q != '0) && !bus.adder_valid;
  assign pop_c      = !fifo_empty && bus.out_ready;

  // Result buffer, written only for results that were actually issued
  sync_fifo_w #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (collect_c),
    .data_i  (bus.adder_y),
    .pop_i   (pop_c),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state for in-flight count, watchdog and sticky error flags
  always_comb begin
    outstanding_d  = outstanding_q;
    wd_d           = wd_q;
    err_protocol_d = err_protocol_q;
    err_timeout_d  = err_timeout_q;

    case ({accept_c, collect_c})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (wd_run_c) begin
      if (wd_q != TW'(TIMEOUT)) begin
        wd_d = wd_q + TW'(1);
      end
    end else begin
      wd_d = '0;
    end

    // Flag lands on the edge where the stall count reaches TIMEOUT
    if (wd_run_c && (wd_q == TW'(TIMEOUT - 1))) begin
      err_timeout_d = 1'b1;
    end

    if (spurious_c || (collect_c && fifo_full)) begin
      err_protocol_d = 1'b1;
    end
  end

  // Issue register, counters and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adder_start_q  <= 1'b0;
      adder_a_q      <= '0;
      adder_b_q      <= '0;
      outstanding_q  <= '0;
      wd_q           <= '0;
      err_protocol_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      adder_start_q <= accept_c;
      if (accept_c) begin
        adder_a_q <= bus.in_a;
        adder_b_q <= bus.in_b;
      end
      outstanding_q  <= outstanding_d;
      wd_q           <= wd_d;
      err_protocol_q <= err_protocol_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.adder_start  = adder_start_q;
  assign bus.adder_a      = adder_a_q;
  assign bus.adder_b      = adder_b_q;
  assign bus.out_valid    = !fifo_empty;
  assign bus.out_y        = fifo_head;
  assign bus.outstanding  = outstanding_q;
  assign bus.err_protocol = err_protocol_q;
  assign bus.err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_add_issue_collect.sv
// Bench for add_issue_collect: two-stage adder model, result scoreboard,
// vector table plus hand-written corner-case sequences.
module tb_add_issue_collect;
  import add_if_pkg::*;

  localparam int unsigned W       = 10;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    op_pair_t op;
    operand_t y;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_issue_collect_if #(.W(W), .DEPTH(DEPTH)) bus ();

  add_issue_collect #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Two-stage adder model: start at cycle n -> adder_valid during cycle n+2
  logic         stall;
  logic         spur;
  logic [W-1:0] spur_y;
  logic         s1_v, s2_v;
  logic [W-1:0] s1_y, s2_y;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_y <= '0; s2_y <= '0;
    end else begin
      s1_v <= bus.adder_start && !stall;
      s1_y <= bus.adder_a + bus.adder_b;
      s2_v <= s1_v;
      s2_y <= s1_y;
    end
  end

  assign bus.adder_valid = s2_v || spur;
  assign bus.adder_y     = spur ? spur_y : s2_y;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Scoreboard: every downstream handshake pops the oldest expected result
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("out_y", 32'(bus.out_y), 32'(exp_q.pop_front()));
      end
    end
  end

  // Present one pair until accepted (bounded); returns just after the accept edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit track, input logic [W-1:0] y);
    bit ok = 1'b0;
    bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    chk("accept_wait", 32'(ok), 32'd1);
    if (ok && track) exp_q.push_back(y);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has come out and nothing is in flight
  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !bus.out_valid && (bus.outstanding == '0);
    end
    chk(name, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{op: '{a: 10'd3,   b: 10'd4},   y: 10'd7};
    vecs[1] = '{op: '{a: 10'd1023, b: 10'd1},  y: 10'd0};
    vecs[2] = '{op: '{a: 10'd512, b: 10'd512}, y: 10'd0};
    vecs[3] = '{op: '{a: 10'd100, b: 10'd200}, y: 10'd300};
    vecs[4] = '{op: '{a: 10'd1000, b: 10'd50}, y: 10'd26};
    vecs[5] = '{op: '{a: 10'd511, b: 10'd511}, y: 10'd1022};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    stall = 1'b0; spur = 1'b0; spur_y = '0;

    // Reset state
    #12;
    chk("rst_in_ready",     32'(bus.in_ready), 32'd0);
    chk("rst_out_valid",    32'(bus.out_valid), 32'd0);
    chk("rst_outstanding",  32'(bus.outstanding), 32'd0);
    chk("rst_adder_start",  32'(bus.adder_start), 32'd0);
    chk("rst_out_y",        32'(bus.out_y), 32'd0);
    chk("rst_err_protocol", 32'(bus.err_protocol), 32'd0);
    chk("rst_err_timeout",  32'(bus.err_timeout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single op: issue timing and result latency
    bus.in_a = 10'd3; bus.in_b = 10'd4; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(10'd7);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    chk("t1_start_t1",     32'(bus.adder_start), 32'd1);
    chk("t1_adder_a",      32'(bus.adder_a), 32'd3);
    chk("t1_adder_b",      32'(bus.adder_b), 32'd4);
    chk("t1_outstanding1", 32'(bus.outstanding), 32'd1);
    @(posedge clk); #1;
    chk("t1_start_t2",     32'(bus.adder_start), 32'd0);
    chk("t1_out_valid_t2", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_out_valid_t3", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_out_valid",    32'(bus.out_valid), 32'd1);
    chk("t1_out_y",        32'(bus.out_y), 32'd7);
    chk("t1_outstanding0", 32'(bus.outstanding), 32'd0);
    wait_drain("t1_drain");

    // Vector table, back-to-back with downstream always ready (includes wrap cases)
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].op.a, vecs[i].op.b, 1'b1, vecs[i].y);
    end
    wait_drain("table_drain");

    // Back-pressure: credits run out after four accepts, results keep order
    bus.out_ready = 1'b0;
    send(10'd10,   10'd20, 1'b1, 10'd30);
    send(10'd30,   10'd40, 1'b1, 10'd70);
    send(10'd1000, 10'd24, 1'b1, 10'd0);
    send(10'd7,    10'd8,  1'b1, 10'd15);
    chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_in_ready_buffered", 32'(bus.in_ready), 32'd0);
    chk("bp_outstanding",       32'(bus.outstanding), 32'd0);
    chk("bp_out_valid",         32'(bus.out_valid), 32'd1);
    chk("bp_head",              32'(bus.out_y), 32'd30);
    bus.out_ready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_in_ready_again", 32'(bus.in_ready), 32'd1);

    // Spurious adder_valid with nothing outstanding
    spur_y = 10'd55; spur = 1'b1;
    @(posedge clk); #1; spur = 1'b0;
    chk("spur_err_protocol", 32'(bus.err_protocol), 32'd1);
    chk("spur_out_valid",    32'(bus.out_valid), 32'd0);
    chk("spur_outstanding",  32'(bus.outstanding), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("spur_err_sticky", 32'(bus.err_protocol), 32'd1);

    // Stalled adder: watchdog fires exactly TIMEOUT cycles after the issue strobe
    stall = 1'b1;
    send(10'd5, 10'd6, 1'b0, 10'd11);
    chk("wd_start", 32'(bus.adder_start), 32'd1);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    chk("wd_not_yet", 32'(bus.err_timeout), 32'd0);
    @(posedge clk); #1;
    chk("wd_err_timeout",  32'(bus.err_timeout), 32'd1);
    chk("wd_in_ready",     32'(bus.in_ready), 32'd0);
    chk("wd_outstanding",  32'(bus.outstanding), 32'd1);

    // Reset clears the sticky errors
    rst_n = 1'b0; stall = 1'b0;
    #1;
    chk("rst2_err_protocol", 32'(bus.err_protocol), 32'd0);
    chk("rst2_err_timeout",  32'(bus.err_timeout), 32'd0);
    chk("rst2_outstanding",  32'(bus.outstanding), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset with two ops in flight and one buffered, then a clean op
    bus.out_ready = 1'b0;
    send(10'd1, 10'd2, 1'b1, 10'd3);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(posedge clk); #1;
        seen = bus.out_valid;
      end
      chk("mid_buffered", 32'(seen), 32'd1);
    end
    send(10'd4, 10'd5, 1'b1, 10'd9);
    send(10'd6, 10'd7, 1'b1, 10'd13);
    chk("mid_outstanding2", 32'(bus.outstanding), 32'd2);
    chk("mid_out_valid",    32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid",    32'(bus.out_valid), 32'd0);
    chk("mid_rst_outstanding",  32'(bus.outstanding), 32'd0);
    chk("mid_rst_err_protocol", 32'(bus.err_protocol), 32'd0);
    chk("mid_rst_err_timeout",  32'(bus.err_timeout), 32'd0);
    chk("mid_rst_in_ready",     32'(bus.in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send(10'd20, 10'd22, 1'b1, 10'd42);
    wait_drain("post_rst_drain");
    chk("post_rst_err_protocol", 32'(bus.err_protocol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
